// File: rtl/sdm_dac.sv
// sdm_dac: delta-sigma 1-bit DAC with a sample handshake and a selectable
// first/second-order modulator.
//
// Ports:
//   clk          system clock, all state on its rising edge
//   rst          synchronous active-high reset
//   din          signed W-bit PCM sample
//   din_stb      one-clock strobe that offers din
//   din_rdy      holding register empty (din_stb is accepted)
//   order2       modulator order request, 0 = first, 1 = second
//   mute         forces the modulator input to zero
//   sample_tick  one-clock pulse after each sample-period wrap
//   underrun     sticky flag: a wrap found the holding register empty
//   dac_out      registered 1-bit density-modulated output
module sdm_dac #(
    parameter int W          = 10,
    parameter int SAMPLE_DIV = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] din,
    input  logic                din_stb,
    output logic                din_rdy,
    input  logic                order2,
    input  logic                mute,
    output logic                sample_tick,
    output logic                underrun,
    output logic                dac_out
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int IW = W + 4;
    localparam int SW = W + 6;

    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

    localparam logic signed [SW-1:0] HALF = SW'(2 ** (W - 1));
    localparam logic signed [SW-1:0] LIM  = SW'(2 ** (W + 2) - 1);

    // Sample path state
    logic [CW-1:0]        r_cnt;
    logic                 r_tick;
    logic signed [W-1:0]  r_hold;
    logic                 r_hold_valid;
    logic signed [W-1:0]  r_cur;
    logic                 r_underrun;
    logic                 r_mode;

    // Modulator state
    logic signed [W-1:0]  r_x;
    logic [W-1:0]         r_acc;
    logic signed [IW-1:0] r_i1;
    logic signed [IW-1:0] r_i2;
    logic                 r_dac;

    logic                 w_wrap;
    logic                 w_accept;
    logic                 w_mode_chg;

    logic [W-1:0]         w_u;
    logic [W:0]           w_sum1;

    logic signed [SW-1:0] w_x_ext;
    logic signed [SW-1:0] w_fb;
    logic signed [SW-1:0] w_s1;
    logic signed [SW-1:0] w_s2;
    logic signed [IW-1:0] w_i1n;
    logic signed [IW-1:0] w_i2n;

    // Clamp to +/-(2^(W+2)-1); the sum width leaves headroom so the
    // comparison itself can never wrap.
    function automatic logic signed [IW-1:0] f_sat(
        input logic signed [SW-1:0] v
    );
        if (v > LIM) begin
            return IW'(LIM);
        end else if (v < -LIM) begin
            return IW'(-LIM);
        end else begin
            return IW'(v);
        end
    endfunction

    // ------------------------------------------------------------
    // Period counter and handshake
    // ------------------------------------------------------------
    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_accept   = din_stb & ~r_hold_valid;
    assign w_mode_chg = w_wrap & (order2 != r_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_tick       <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_cur        <= '0;
            r_underrun   <= 1'b0;
            r_mode       <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
            r_tick <= w_wrap;

            if (w_wrap) begin
                r_mode <= order2;
            end

            // A full holding register blocks the strobe, so a wrap that
            // drains hold can never coincide with a new accept.
            if (w_wrap && r_hold_valid) begin
                r_cur        <= r_hold;
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold       <= din;
                r_hold_valid <= 1'b1;
            end

            if (w_wrap && !r_hold_valid) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------
    // First-order datapath: offset-binary phase accumulator
    // ------------------------------------------------------------
    assign w_u    = {~r_x[W-1], r_x[W-2:0]};
    assign w_sum1 = {1'b0, r_acc} + {1'b0, w_u};

    // ------------------------------------------------------------
    // Second-order datapath: two saturating integrators
    // ------------------------------------------------------------
    assign w_x_ext = SW'(r_x);
    assign w_fb    = r_dac ? HALF : -HALF;
    assign w_s1    = SW'(r_i1) + w_x_ext - w_fb;
    assign w_i1n   = f_sat(w_s1);
    assign w_s2    = SW'(r_i2) + SW'(w_i1n) - w_fb;
    assign w_i2n   = f_sat(w_s2);

    // The modulator input is registered so mute and new samples reach
    // dac_out through exactly two flops with no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_acc <= '0;
            r_i1  <= '0;
            r_i2  <= '0;
            r_dac <= 1'b0;
        end else begin
            r_x <= mute ? '0 : r_cur;

            if (r_mode) begin
                r_i1  <= w_i1n;
                r_i2  <= w_i2n;
                r_dac <= ~w_i2n[IW-1];
            end else begin
                r_acc <= w_sum1[W-1:0];
                r_dac <= w_sum1[W];
            end

            // Switching order restarts from clean integrators so the new
            // loop never inherits state it cannot interpret.
            if (w_mode_chg) begin
                r_acc <= '0;
                r_i1  <= '0;
                r_i2  <= '0;
            end
        end
    end

    assign din_rdy     = ~r_hold_valid;
    assign sample_tick = r_tick;
    assign underrun    = r_underrun;
    assign dac_out     = r_dac;

endmodule

// File: tb/tb_sdm_dac.sv
// tb_sdm_dac: directed bench for sdm_dac with an integer reference model
// compared every cycle, plus literal density and handshake expectations.
module tb_sdm_dac;

    localparam int W    = 10;
    localparam int DIV  = 256;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int LIMI = (1 << (W + 2)) - 1;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] din;
    logic                din_stb;
    logic                din_rdy;
    logic                order2;
    logic                mute;
    logic                sample_tick;
    logic                underrun;
    logic                dac_out;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    bit feed     = 0;
    int feed_val = 0;

    sdm_dac #(.W(W), .SAMPLE_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_stb    (din_stb),
        .din_rdy    (din_rdy),
        .order2     (order2),
        .mute       (mute),
        .sample_tick(sample_tick),
        .underrun   (underrun),
        .dac_out    (dac_out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > LIMI) return LIMI;
        if (v < -LIMI) return -LIMI;
        return v;
    endfunction

    // Reference model: plain integers following the behavioural rules
    int m_cnt, m_hold, m_hv, m_cur, m_x, m_mode;
    int m_acc, m_i1, m_i2, m_dac, m_tick, m_und;

    always @(posedge clk) begin
        int nx, s, f, a, b;
        bit wrap;
        if (rst) begin
            m_cnt = 0; m_hold = 0; m_hv = 0; m_cur = 0; m_x = 0;
            m_mode = 0; m_acc = 0; m_i1 = 0; m_i2 = 0;
            m_dac = 0; m_tick = 0; m_und = 0;
        end else begin
            wrap = (m_cnt == DIV - 1);
            nx = mute ? 0 : m_cur;
            if (m_mode == 0) begin
                s = m_acc + m_x + HALF;
                m_dac = (s >= FULL) ? 1 : 0;
                m_acc = s % FULL;
            end else begin
                f = m_dac ? HALF : -HALF;
                a = clamp(m_i1 + m_x - f);
                b = clamp(m_i2 + a - f);
                m_i1 = a;
                m_i2 = b;
                m_dac = (b >= 0) ? 1 : 0;
            end
            m_x = nx;
            if (wrap && int'(order2) != m_mode) begin
                m_acc = 0; m_i1 = 0; m_i2 = 0;
            end
            if (wrap) m_mode = int'(order2);
            m_tick = wrap ? 1 : 0;
            if (wrap) begin
                if (m_hv != 0) begin
                    m_cur = m_hold;
                    m_hv = 0;
                end else begin
                    m_und = 1;
                    if (din_stb) begin
                        m_hold = int'(din);
                        m_hv = 1;
                    end
                end
            end else if (din_stb && m_hv == 0) begin
                m_hold = int'(din);
                m_hv = 1;
            end
            m_cnt = wrap ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        int i1v, i2v;
        if (chk_en) begin
            chk("dac_out", int'(dac_out), m_dac);
            chk("sample_tick", int'(sample_tick), m_tick);
            chk("din_rdy", int'(din_rdy), (m_hv == 0) ? 1 : 0);
            chk("underrun", int'(underrun), m_und);
            i1v = int'(dut.r_i1);
            i2v = int'(dut.r_i2);
            chk("integ_range",
                (i1v >= -LIMI && i1v <= LIMI &&
                 i2v >= -LIMI && i2v <= LIMI) ? 1 : 0, 1);
        end
    end

    task automatic apply_feed();
        if (feed) begin
            din     = W'(feed_val);
            din_stb = din_rdy;
        end else begin
            din_stb = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        apply_feed();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 2 * DIV + 4; i++) begin
            step();
            if (sample_tick) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic count(input int n, output int ones, output int ticks);
        ones = 0;
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            ones += int'(dac_out);
            ticks += int'(sample_tick);
        end
    endtask

    task automatic win4(input int n, output int bad);
        int q [4];
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            q[i % 4] = int'(dac_out);
            if (i >= 3 && (q[0] + q[1] + q[2] + q[3]) != 3) bad++;
        end
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int ones, ticks, bad, n;

        rst = 1; din = 0; din_stb = 0; order2 = 0; mute = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_dac", int'(dac_out), 0);
        chk("rst_tick", int'(sample_tick), 0);
        chk("rst_und", int'(underrun), 0);
        chk("rst_rdy", int'(din_rdy), 1);

        // First order, +256 -> 3 ones in every 4 clocks
        rst = 0;
        feed = 1;
        feed_val = 256;
        apply_feed();
        run(DIV + 16);
        win4(1024, bad);
        chk("fo_win4_bad", bad, 0);
        chk("fo_underrun", int'(underrun), 0);
        wait_tick();
        n = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            n++;
            if (sample_tick) break;
        end
        chk("tick_period", n, DIV);

        // First order, full negative and mid-scale
        feed_val = -512;
        run(2 * DIV + 8);
        count(256, ones, ticks);
        chk("fo_neg_ones", ones, 0);
        feed_val = 0;
        run(2 * DIV + 8);
        count(1024, ones, ticks);
        chk("fo_zero_ones", ones, 512);
        chk("fo_zero_ticks", ticks, 4);

        // Handshake: second strobe while full is dropped
        feed = 0;
        step();
        wait_tick();
        din = 100; din_stb = 1;
        @(negedge clk);
        chk("hs_rdy_busy", int'(din_rdy), 0);
        din = 200; din_stb = 1;
        @(negedge clk);
        din_stb = 0;
        wait_tick();
        chk("hs_cur_100", int'(dut.r_cur), 100);
        chk("hs_und_pre", int'(underrun), 0);
        // Strobe exactly in the wrap cycle with hold empty
        repeat (DIV - 1) @(negedge clk);
        din = 300; din_stb = 1;
        @(negedge clk);
        din_stb = 0;
        chk("hs_und_set", int'(underrun), 1);
        chk("hs_cur_keep", int'(dut.r_cur), 100);
        chk("hs_rdy_load", int'(din_rdy), 0);
        wait_tick();
        chk("hs_cur_300", int'(dut.r_cur), 300);

        // Second order densities
        order2 = 1;
        feed = 1;
        feed_val = 256;
        run(2 * DIV + 16);
        count(4096, ones, ticks);
        chk("so_pos_ones", (ones >= 3068 && ones <= 3076) ? 1 : 0, 1);
        feed_val = -256;
        run(2 * DIV + 16);
        count(4096, ones, ticks);
        chk("so_neg_ones", (ones >= 1020 && ones <= 1028) ? 1 : 0, 1);
        feed_val = 511;
        run(4096);

        // Mode switch takes effect only at the wrap edge
        order2 = 0;
        feed_val = 256;
        run(2 * DIV + 8);
        wait_tick();
        run(100);
        order2 = 1;
        step();
        chk("mode_hold", int'(dut.r_mode), 0);
        wait_tick();
        chk("mode_new", int'(dut.r_mode), 1);
        chk("clr_i1", int'(dut.r_i1), 0);
        chk("clr_i2", int'(dut.r_i2), 0);
        chk("clr_acc", int'(dut.r_acc), 0);
        run(16);
        mute = 1;
        run(16);
        count(256, ones, ticks);
        chk("mute_ones", (ones >= 124 && ones <= 132) ? 1 : 0, 1);
        chk("mute_ticks", ticks, 1);
        mute = 0;

        // Reset mid-period with hold full and underrun set
        wait_tick();
        run(50);
        chk("pre_rst_rdy", int'(din_rdy), 0);
        chk("pre_rst_und", int'(underrun), 1);
        rst = 1;
        feed = 0;
        din_stb = 0;
        @(negedge clk);
        rst = 0;
        chk("mrst_dac", int'(dac_out), 0);
        chk("mrst_tick", int'(sample_tick), 0);
        chk("mrst_und", int'(underrun), 0);
        chk("mrst_rdy", int'(din_rdy), 1);
        chk("mrst_cnt", int'(dut.r_cnt), 0);
        n = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            n++;
            if (sample_tick) break;
        end
        chk("first_wrap", n, DIV);
        chk("first_und", int'(underrun), 1);

        run(4);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdm_dac.md
# sdm_dac

Parametrised delta-sigma 1-bit DAC for the Speech256 output path: it takes signed PCM samples from the filter/source chain through a ready/strobe handshake and produces a single-bit density-modulated stream for an external RC filter. It generalises the existing PWM DAC with configurable sample width and sample period, a selectable first/second-order modulator, a one-deep holding buffer, a sample-request pulse, mute, and underrun detection.

## Interface
Parameters:
- W, 10, sample width in bits (signed two's complement), 4..16.
- SAMPLE_DIV, 256, clocks per sample period, ≥ 4.

Ports:
- clk  in  1  system clock; every register in the block is clocked on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- din  in  W  signed PCM sample.
- din_stb  in  1  sample strobe, one clock per sample.
- din_rdy  out  1  holding register empty; equals ~hold_valid.
- order2  in  1  0 = first-order modulator, 1 = second-order modulator.
- mute  in  1  forces modulator input to 0.
- sample_tick  out  1  one-clock pulse at each sample-period boundary; upstream uses it as the request for the next sample.
- underrun  out  1  sticky flag; cleared only by rst.
- dac_out  out  1  registered 1-bit modulator output.

## Operation
- Holding register: when din_stb=1 and din_rdy=1, hold ← din and hold_valid ← 1. When din_stb=1 and din_rdy=0, the strobe is ignored and hold is unchanged.
- Period counter cnt counts 0..SAMPLE_DIV-1 and wraps. The wrap cycle is the cycle with cnt = SAMPLE_DIV-1. sample_tick is registered and is 1 for the clock following the wrap cycle.
- At the wrap edge:
  - If hold_valid=1: cur ← hold and hold_valid ← 0. A din_stb in the same cycle is accepted only if din_rdy was already 1, so it cannot be accepted here.
  - If hold_valid=0: cur keeps its value and underrun ← 1. A din_stb in the same cycle loads hold but is not forwarded to cur.
  - mode ← order2. If mode changes, the integrators acc, i1 and i2 are cleared on that edge.
- Modulator input: x = mute ? 0 : cur. mute acts on the next clock and has no effect on the handshake.
- First order (mode=0):
  - u = x + 2^(W-1), an unsigned W-bit value.
  - {c, acc} ← acc + u, with acc W bits wide and c the carry.
  - dac_out ← c.
  - The long-run density of dac_out is exactly u/2^W.
- Second order (mode=1):
  - Signed integrators i1 and i2, each W+4 bits.
  - Feedback f = dac_out ? +2^(W-1) : -2^(W-1).
  - i1 ← sat(i1 + x − f), then i2 ← sat(i2 + i1_new − f).
  - sat clamps to ±(2^(W+2)−1).
  - dac_out ← (i2_new ≥ 0).
- Reset values: cnt=0, hold_valid=0 (so din_rdy=1), hold=0, cur=0, mode=0, acc=0, i1=0, i2=0, dac_out=0, sample_tick=0, underrun=0.
- Reset takes effect on the next rising edge whenever asserted, including mid-period; no partial state survives.

## Timing
- Sample latency: from the din_stb edge to cur updating is up to SAMPLE_DIV clocks, determined by the next wrap edge. The first dac_out bit influenced by the new cur appears 2 clocks after that wrap edge.
- Upstream may present a sample any time din_rdy=1. The recommended practice is to strobe within SAMPLE_DIV−1 clocks after sample_tick.
- The first wrap after reset occurs SAMPLE_DIV clocks after rst deasserts. With no sample loaded by then, underrun goes to 1.
- dac_out toggles at most once per clock and has no combinational path from any input.

## Test plan
- Reset, W=10, order2=0: load din=+256 before the first wrap. After the wrap, every 4-clock window of dac_out has exactly 3 ones; underrun=0; sample_tick pulses every 256 clocks.
- First order, din=−512: dac_out is all 0 after latency. din=0: dac_out is 0101…, density exactly 1/2 over every 1024 clocks.
- Handshake: strobe din=100, then strobe din=200 while din_rdy=0. Required: 200 is dropped and cur=100 after the wrap. A strobe in the wrap cycle with hold empty sets underrun and leaves cur unchanged; the strobed value reaches cur at the next wrap.
- Second order, din=+256 and then −256, 4096 clocks each: the ones count is within ±4 of 3072 and then of 1024. Driving din=+511 keeps i1 and i2 within saturation bounds with no wrap-around; an assertion on the integrator range covers this.
- Set order2=1 mid-period: mode and the integrator clear occur only at the next wrap edge. Then assert mute: dac_out density becomes 1/2 within 16 clocks while sample_tick and din_rdy behaviour are unchanged.
- Assert rst for 1 clock mid-period with hold_valid=1 and underrun=1. Required on the next clock: all outputs at their reset values, din_rdy=1, and cnt restarting from 0.
